vcode_engine: RTL and testbench
===============================

// Module: vcode_engine
// PURPOSE
// Parametrised TX/RX verification-code engine for RIFL frames. A frame is FRAME_WIDTH/DWIDTH beats, MSB-first.
// GEN mode writes CRC^frame_id into the low CRC_WIDTH bits of the tail beat.
// CHK mode recomputes that value on the RX side, flags mismatches and tracks the expected frame_id.
// Adds two things: a valid qualifier that lets beats stall, and sof-abort detection.
// PARAMETERS
// FRAME_WIDTH     256     frame bits; must be DWIDTH * 2^k (k>=0)
// DWIDTH          64      beat width; must be > CRC_WIDTH
// CRC_WIDTH       12      CRC field width
// CRC_POLY        12'h02f polynomial, normal representation, implicit x^CRC_WIDTH
// FRAME_ID_WIDTH  8       frame id width; must be <= CRC_WIDTH, zero-extended before XOR
// MODE            0       0 = GEN (TX), 1 = CHK (RX)
// ERR_CNT_WIDTH   16      saturating error counter width
// PORTS
// clk        in   1               single clock
// rst        in   1               asynchronous, active-high reset
// in_valid   in   1               beat qualifier; no backpressure
// sof        in   1               first beat of frame; sampled only when in_valid=1
// data_in    in   DWIDTH          beat data
// out_valid  out   1              registered copy of in_valid
// data_out   out  DWIDTH          processed beat
// frame_ok   out  1               CHK: 1-cycle pulse, tail beat CRC match (GEN: tail done)
// crc_err    out  1               CHK: 1-cycle pulse on tail mismatch (GEN: tied 0)
// sof_err    out  1               1-cycle pulse, sof received mid-frame
// err_cnt    out  ERR_CNT_WIDTH   saturating count of crc_err + sof_err events
// frame_id   out  FRAME_ID_WIDTH  current (GEN) / expected (CHK) frame id
// BEHAVIOUR
// - Reset (async assert): all outputs, beat counter, crc state, frame_id and in_frame go to 0. Reset is released synchronously to clk.
// - Latency 1 cycle: out_valid/data_out/pulses at cycle n+1 for an accepted beat at n.
// - Cycles with in_valid=0 hold all state. out_valid=0 and data_out holds its last value.
// - CRC: shift-register per bit, MSB first, seeded 0 at every sof, run over all beats.
//   The tail beat's low CRC_WIDTH bits enter the CRC as zeros in both modes.
// - Beat counter beat_cnt of width max(1,log2(BEATS)). sof sets beat 0 and in_frame=1.
//   Tail beat: beat_cnt==BEATS-1, or sof when BEATS==1. in_frame clears after the tail beat.
// - Frame type: data frame iff data_in[DWIDTH-1-:2]==2'b01 on the sof beat; the flag is latched for the frame.
// - GEN tail: data_out = {data_in[DWIDTH-1:CRC_WIDTH], crc ^ frame_id}; frame_ok pulses.
//   Data frames then increment frame_id (mod 2^FRAME_ID_WIDTH). Non-tail beats pass unmodified.
// - CHK tail: expect = crc ^ frame_id, compared against data_in[CRC_WIDTH-1:0].
//   On match: frame_ok pulses, and data frames increment frame_id.
//   On mismatch: crc_err pulses and frame_id holds (go-back-N; retransmit reuses the id).
//   data_out always passes data_in unmodified.
// - sof while in_frame: the partial frame is aborted with no frame_id change and no frame_ok/crc_err, sof_err pulses.
//   The new frame starts on this same beat.
// - Valid beat without sof while !in_frame: passes through with no CRC and no pulses.
// - crc_err and sof_err in the same cycle cannot occur (aborted tail is not checked). err_cnt +1 per event, saturates at all-ones.
// - frame_id wraps from 2^FRAME_ID_WIDTH-1 to 0.
// STRUCTURE
// - vcode_pkg: mode_e {VC_GEN, VC_CHK}; function crc_step(crc, data) (DWIDTH-bit unrolled); BEATS/CNT_WIDTH localparam helpers.
// - Sub-module vcode_crc_step: combinational CRC_WIDTH x DWIDTH update, shared by GEN and CHK paths.
// - Elaboration assertions on parameter legality.
// TESTING
// - Run every scenario with BEATS=4 and BEATS=1. Golden model is a bitwise C-style CRC-12 with poly 0x02f.
// 1 GEN: 3 back-to-back data frames, id 0,1,2 -> each tail CRC field == golden ^ id; frame_id ends at 3.
// 2 GEN: control frame (top bits 2'b10) between data frames -> field == golden ^ current id; frame_id does not increment.
// 3 CHK: GEN output looped into CHK with random in_valid gaps (50%) -> 100 frame_ok, 0 crc_err, frame_ids equal.
// 4 CHK: flip bit 37 of beat 2 -> crc_err pulse, frame_id held; resend clean frame -> frame_ok, id+1; err_cnt=1.
// 5 sof on beat 2 of a frame -> sof_err pulse; new frame completes correctly; frame_id unchanged by the aborted frame.
// 6 Assert rst mid-frame (beat 1) -> outputs 0 immediately (async); next frame checked with id 0.
//   Also: 256 data frames -> frame_id wraps to 0; ERR_CNT_WIDTH=2 with 5 errors -> err_cnt=3.

Source files
------------

// File: rtl/vcode_pkg.sv
// Shared types and helpers for the RIFL verification-code engine.
// Holds the mode encoding, frame geometry helpers and the bit-serial CRC update.
package vcode_pkg;

  typedef enum logic {
    VC_GEN = 1'b0,
    VC_CHK = 1'b1
  } mode_e;

  localparam int MAX_CRC_W = 32;
  localparam int MAX_DW    = 1024;

  function automatic int beats_f(input int frame_width, input int dwidth);
    return frame_width / dwidth;
  endfunction

  function automatic int cnt_width_f(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // One beat of an MSB-first shift-register CRC. Bits at and above crc_width
  // accumulate shifted-out garbage that never feeds back; callers truncate.
  function automatic logic [MAX_CRC_W-1:0] crc_step(
    input logic [MAX_CRC_W-1:0] crc,
    input logic [MAX_DW-1:0]    data,
    input int                   dwidth,
    input int                   crc_width,
    input logic [MAX_CRC_W-1:0] poly
  );
    logic [MAX_CRC_W-1:0] c;
    logic                 fb;
    c = crc;
    for (int i = dwidth - 1; i >= 0; i--) begin
      fb = c[crc_width-1] ^ data[i];
      c  = c << 1;
      if (fb) c = c ^ poly;
    end
    return c;
  endfunction

endpackage

// File: rtl/vcode_crc_step.sv
// Combinational CRC_WIDTH x DWIDTH update, one full beat per evaluation.
module vcode_crc_step
  import vcode_pkg::*;
#(
  parameter int                   DWIDTH    = 64,
  parameter int                   CRC_WIDTH = 12,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 12'h02f
) (
  input  logic [CRC_WIDTH-1:0] crc_in,
  input  logic [DWIDTH-1:0]    data,
  output logic [CRC_WIDTH-1:0] crc_out
);

  assign crc_out = CRC_WIDTH'(crc_step(MAX_CRC_W'(crc_in), MAX_DW'(data), DWIDTH, CRC_WIDTH,
                                       MAX_CRC_W'(CRC_POLY)));

endmodule

// File: rtl/vcode_engine.sv
// RIFL verification-code engine: GEN writes CRC^frame_id into the tail beat,
// CHK recomputes it, flags mismatches and tracks the expected frame id.
module vcode_engine
  import vcode_pkg::*;
#(
  parameter int                   FRAME_WIDTH    = 256,
  parameter int                   DWIDTH         = 64,
  parameter int                   CRC_WIDTH      = 12,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY       = 12'h02f,
  parameter int                   FRAME_ID_WIDTH = 8,
  parameter int                   MODE           = 0,
  parameter int                   ERR_CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      sof,
  input  logic [DWIDTH-1:0]         data_in,
  output logic                      out_valid,
  output logic [DWIDTH-1:0]         data_out,
  output logic                      frame_ok,
  output logic                      crc_err,
  output logic                      sof_err,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt,
  output logic [FRAME_ID_WIDTH-1:0] frame_id
);

  localparam int                   BEATS     = beats_f(FRAME_WIDTH, DWIDTH);
  localparam int                   CNT_WIDTH = cnt_width_f(BEATS);
  localparam mode_e                MODE_E    = mode_e'(MODE[0]);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);

  if (BEATS < 1 || (FRAME_WIDTH % DWIDTH) != 0 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_frame
    $fatal(1, "FRAME_WIDTH must be DWIDTH * 2^k");
  end
  if (DWIDTH <= CRC_WIDTH || DWIDTH > MAX_DW) begin : g_bad_dwidth
    $fatal(1, "DWIDTH must exceed CRC_WIDTH and fit the CRC helper");
  end
  if (CRC_WIDTH < 1 || CRC_WIDTH > MAX_CRC_W) begin : g_bad_crc
    $fatal(1, "CRC_WIDTH out of range");
  end
  if (FRAME_ID_WIDTH < 1 || FRAME_ID_WIDTH > CRC_WIDTH) begin : g_bad_id
    $fatal(1, "FRAME_ID_WIDTH must be 1..CRC_WIDTH");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $fatal(1, "MODE must be 0 (GEN) or 1 (CHK)");
  end
  if (ERR_CNT_WIDTH < 1) begin : g_bad_cnt
    $fatal(1, "ERR_CNT_WIDTH must be positive");
  end

  logic [CNT_WIDTH-1:0] beat_cnt, cur_idx;
  logic                 in_frame, data_flag;
  logic [CRC_WIDTH-1:0] crc_q, crc_seed, crc_next, vcode;
  logic [DWIDTH-1:0]    crc_data;
  logic                 active, is_tail, is_data, abort, match, tail_ok, tail_bad;

  // NOTE: every always_comb output is assigned on every path so no latch is inferred.
  always_comb begin
    abort    = in_valid & sof & in_frame;
    active   = in_valid & (sof | in_frame);
    cur_idx  = sof ? '0 : beat_cnt;
    is_tail  = active & (cur_idx == LAST_BEAT);
    is_data  = sof ? (data_in[DWIDTH-1 -: 2] == 2'b01) : data_flag;
    crc_seed = sof ? '0 : crc_q;
    crc_data = is_tail ? {data_in[DWIDTH-1:CRC_WIDTH], {CRC_WIDTH{1'b0}}} : data_in;
    vcode    = crc_next ^ CRC_WIDTH'(frame_id);
    match    = (vcode == data_in[CRC_WIDTH-1:0]);
    tail_ok  = is_tail & ((MODE_E == VC_GEN) | match);
    tail_bad = is_tail & (MODE_E == VC_CHK) & ~match;
  end

  vcode_crc_step #(
    .DWIDTH   (DWIDTH),
    .CRC_WIDTH(CRC_WIDTH),
    .CRC_POLY (CRC_POLY)
  ) u_crc_step (
    .crc_in (crc_seed),
    .data   (crc_data),
    .crc_out(crc_next)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      frame_ok  <= 1'b0;
      crc_err   <= 1'b0;
      sof_err   <= 1'b0;
      err_cnt   <= '0;
      frame_id  <= '0;
      beat_cnt  <= '0;
      in_frame  <= 1'b0;
      data_flag <= 1'b0;
      crc_q     <= '0;
    end else begin
      out_valid <= in_valid;
      frame_ok  <= 1'b0;
      crc_err   <= 1'b0;
      sof_err   <= 1'b0;
      if (in_valid) begin
        data_out <= (MODE_E == VC_GEN && is_tail) ? {data_in[DWIDTH-1:CRC_WIDTH], vcode} : data_in;
        frame_ok <= tail_ok;
        crc_err  <= tail_bad;
        sof_err  <= abort;
        if (active) begin
          crc_q     <= crc_next;
          data_flag <= is_data;
          in_frame  <= ~is_tail;
          beat_cnt  <= is_tail ? '0 : cur_idx + CNT_WIDTH'(1);
        end
        // A failed check keeps the id so a go-back-N retransmit reuses it.
        if (tail_ok && is_data) frame_id <= frame_id + FRAME_ID_WIDTH'(1);
        if ((tail_bad || abort) && err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_vcode_engine.sv
// Scoreboard bench for vcode_engine: GEN/CHK pairs at 4 beats and 1 beat per frame,
// compared against a frame-level reference model with a bitwise CRC-12.
module tb_vcode_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // index 0: gen 4-beat, 1: chk 4-beat, 2: gen 1-beat, 3: chk 1-beat
  logic        gv[2], gs[2], tcv[2], tcs[2], cv[2], cs[2], sof_d[2];
  logic [63:0] gd[2], tcd[2], cd[2];
  logic        loop;
  logic        ov[4], ok[4], ce[4], se[4];
  logic [63:0] od[4];
  logic [7:0]  fid[4];
  logic [15:0] ec0, ec1, ec2;
  logic [1:0]  ec3;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      cv[k] = loop ? ov[2*k] : tcv[k];
      cs[k] = loop ? sof_d[k] : tcs[k];
      cd[k] = loop ? od[2*k] : tcd[k];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) sof_d[k] <= gv[k] & gs[k];
  end

  vcode_engine #(.FRAME_WIDTH(256), .DWIDTH(64), .MODE(0)) u_gen4 (
    .clk(clk), .rst(rst), .in_valid(gv[0]), .sof(gs[0]), .data_in(gd[0]),
    .out_valid(ov[0]), .data_out(od[0]), .frame_ok(ok[0]), .crc_err(ce[0]),
    .sof_err(se[0]), .err_cnt(ec0), .frame_id(fid[0]));
  vcode_engine #(.FRAME_WIDTH(256), .DWIDTH(64), .MODE(1)) u_chk4 (
    .clk(clk), .rst(rst), .in_valid(cv[0]), .sof(cs[0]), .data_in(cd[0]),
    .out_valid(ov[1]), .data_out(od[1]), .frame_ok(ok[1]), .crc_err(ce[1]),
    .sof_err(se[1]), .err_cnt(ec1), .frame_id(fid[1]));
  vcode_engine #(.FRAME_WIDTH(64), .DWIDTH(64), .MODE(0)) u_gen1 (
    .clk(clk), .rst(rst), .in_valid(gv[1]), .sof(gs[1]), .data_in(gd[1]),
    .out_valid(ov[2]), .data_out(od[2]), .frame_ok(ok[2]), .crc_err(ce[2]),
    .sof_err(se[2]), .err_cnt(ec2), .frame_id(fid[2]));
  vcode_engine #(.FRAME_WIDTH(64), .DWIDTH(64), .MODE(1), .ERR_CNT_WIDTH(2)) u_chk1 (
    .clk(clk), .rst(rst), .in_valid(cv[1]), .sof(cs[1]), .data_in(cd[1]),
    .out_valid(ov[3]), .data_out(od[3]), .frame_ok(ok[3]), .crc_err(ce[3]),
    .sof_err(se[3]), .err_cnt(ec3), .frame_id(fid[3]));

  typedef struct packed {
    logic [63:0] d;
    logic        ok;
    logic        ce;
    logic        se;
  } exp_t;

  exp_t        q0[$], q1[$], q2[$], q3[$];
  int          n_chk = 0, n_fail = 0;
  int          okc[4];
  int          gid[2], cid[2], gec[2], cec[2];
  bit          gpart[2], cpart[2];
  logic [63:0] fr[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ecv(input int i);
    case (i)
      0:       return ec0;
      1:       return ec1;
      2:       return ec2;
      default: return {14'd0, ec3};
    endcase
  endfunction

  task automatic push(input int i, input logic [63:0] d, input logic o, input logic c, input logic s);
    exp_t e;
    e = '{d: d, ok: o, ce: c, se: s};
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic mon(input int i);
    exp_t e;
    bit   have;
    have = 1'b0;
    e    = '0;
    if (ov[i]) begin
      case (i)
        0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        2:       if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
      endcase
      if (!have) check($sformatf("dut%0d unexpected beat", i), 64'd1, 64'd0);
      else begin
        check($sformatf("dut%0d data_out", i), od[i], e.d);
        check($sformatf("dut%0d ok/crc_err/sof_err", i), {61'd0, ok[i], ce[i], se[i]},
              {61'd0, e.ok, e.ce, e.se});
      end
      if (ok[i]) okc[i]++;
    end else begin
      check($sformatf("dut%0d idle pulses", i), {61'd0, ok[i], ce[i], se[i]}, 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) for (int i = 0; i < 4; i++) mon(i);
  end

  // Bitwise C-style CRC-12, poly 0x02f, MSB first; tail's low 12 bits count as zero.
  function automatic logic [11:0] golden(input int nb);
    int crc, b, fb;
    crc = 0;
    for (int j = 0; j < nb; j++) begin
      for (int i = 63; i >= 0; i--) begin
        b = int'(fr[j][i]);
        if (j == nb - 1 && i < 12) b = 0;
        fb  = ((crc >> 11) & 1) ^ b;
        crc = (crc << 1) & 'hfff;
        if (fb != 0) crc = crc ^ 'h02f;
      end
    end
    return crc[11:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int k, input bit via_gen, input logic v, input logic s, input logic [63:0] d);
    if (via_gen) begin gv[k] = v; gs[k] = s; gd[k] = d; end
    else begin tcv[k] = v; tcs[k] = s; tcd[k] = d; end
    tick();
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    for (int k = 0; k < 2; k++) begin
      gid[k] = 0; cid[k] = 0; gec[k] = 0; cec[k] = 0; gpart[k] = 0; cpart[k] = 0;
    end
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      gv[k] = 0; gs[k] = 0; gd[k] = '0; tcv[k] = 0; tcs[k] = 0; tcd[k] = '0;
    end
  endtask

  task automatic drain();
    repeat (3) tick();
  endtask

  // Send one frame (or its first nsend beats) either through GEN looped into CHK, or straight into CHK.
  task automatic send(input int k, input bit via_gen, input logic [1:0] hdr, input int nsend,
                      input int flip, input bit gaps);
    int          nb;
    logic [11:0] gold;
    logic [63:0] o;
    bit          tail, m;
    nb   = (k == 0) ? 4 : 1;
    loop = via_gen;
    for (int j = 0; j < 4; j++) fr[j] = {$urandom, $urandom};
    fr[0][63:62] = hdr;
    if (!via_gen) begin
      fr[nb-1][11:0] = golden(nb) ^ 12'(cid[k]);
      if (flip >= 0) fr[flip][37] = ~fr[flip][37];
    end
    gold = golden(nb);
    for (int j = 0; j < nsend; j++) begin
      tail = (j == nb - 1);
      o    = fr[j];
      if (via_gen) begin
        if (tail) o[11:0] = gold ^ 12'(gid[k]);
        push(2*k, o, tail, 1'b0, j == 0 && gpart[k]);
        if (j == 0 && gpart[k]) begin gec[k]++; gpart[k] = 0; end
      end
      m = tail && (o[11:0] == (gold ^ 12'(cid[k])));
      push(2*k+1, o, m, tail && !m, j == 0 && cpart[k]);
      if (j == 0 && cpart[k]) begin cec[k]++; cpart[k] = 0; end
      if (tail) begin
        if (via_gen && hdr == 2'b01) gid[k] = (gid[k] + 1) % 256;
        if (m && hdr == 2'b01) cid[k] = (cid[k] + 1) % 256;
        if (!m) cec[k]++;
      end
      if (gaps && $urandom_range(1) == 1) put(k, via_gen, 1'b0, 1'b1, {$urandom, $urandom});
      put(k, via_gen, 1'b1, j == 0, fr[j]);
    end
    if (nsend < nb) begin
      if (via_gen) gpart[k] = 1;
      cpart[k] = 1;
    end
    if (via_gen) begin gv[k] = 0; gs[k] = 0; end
    else begin tcv[k] = 0; tcs[k] = 0; end
  endtask

  task automatic check_ids(input int k, input string tag);
    int cmax;
    cmax = (k == 1) ? 3 : 65535;
    check($sformatf("%s k%0d gen frame_id", tag, k), {56'd0, fid[2*k]}, 64'(gid[k]));
    check($sformatf("%s k%0d chk frame_id", tag, k), {56'd0, fid[2*k+1]}, 64'(cid[k]));
    check($sformatf("%s k%0d gen err_cnt", tag, k), {48'd0, ecv(2*k)}, 64'(gec[k]));
    check($sformatf("%s k%0d chk err_cnt", tag, k), {48'd0, ecv(2*k+1)},
          64'((cec[k] > cmax) ? cmax : cec[k]));
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s dut%0d out_valid", tag, i), {63'd0, ov[i]}, 64'd0);
      check($sformatf("%s dut%0d data_out", tag, i), od[i], 64'd0);
      check($sformatf("%s dut%0d pulses", tag, i), {61'd0, ok[i], ce[i], se[i]}, 64'd0);
      check($sformatf("%s dut%0d frame_id", tag, i), {56'd0, fid[i]}, 64'd0);
      check($sformatf("%s dut%0d err_cnt", tag, i), {48'd0, ecv(i)}, 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, snap;
    loop = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) okc[i] = 0;
    for (int k = 0; k < 2; k++) begin
      nb = (k == 0) ? 4 : 1;
      rst = 1'b1;
      idle_inputs();
      clear_model();
      repeat (2) tick();
      check_zero("reset");
      rst = 1'b0;
      tick();

      // back-to-back data frames, then a control frame between data frames
      for (int f = 0; f < 3; f++) send(k, 1, 2'b01, nb, -1, 0);
      drain();
      check_ids(k, "three data frames");
      send(k, 1, 2'b10, nb, -1, 0);
      drain();
      check_ids(k, "control frame");
      send(k, 1, 2'b01, nb, -1, 0);
      drain();
      check_ids(k, "data after control");

      // looped frames with random valid gaps
      snap = okc[2*k+1];
      for (int f = 0; f < 100; f++) send(k, 1, 2'b01, nb, -1, 1);
      drain();
      check($sformatf("k%0d chk frame_ok count", k), 64'(okc[2*k+1] - snap), 64'd100);
      check_ids(k, "gapped loop");

      // corrupted frame, clean resend, then more errors towards saturation
      send(k, 0, 2'b01, nb, (nb == 4) ? 2 : 0, 0);
      drain();
      check_ids(k, "crc error");
      send(k, 0, 2'b01, nb, -1, 0);
      drain();
      check_ids(k, "clean resend");
      for (int f = 0; f < 4; f++) send(k, 0, 2'b01, nb, (nb == 4) ? 2 : 0, 0);
      drain();
      check_ids(k, "five errors");

      // sof on beat 2 aborts the partial frame
      if (nb == 4) begin
        send(k, 1, 2'b01, 2, -1, 0);
        send(k, 1, 2'b01, nb, -1, 0);
        drain();
        check_ids(k, "sof abort");
      end

      // async reset mid-frame, then frame ids restart and wrap after 256 data frames
      send(k, 1, 2'b01, (nb > 1) ? 2 : 1, -1, 0);
      #2;
      rst = 1'b1;
      #1;
      check_zero("async reset");
      idle_inputs();
      clear_model();
      tick();
      rst = 1'b0;
      tick();
      for (int f = 0; f < 256; f++) send(k, 1, 2'b01, nb, -1, 0);
      drain();
      check_ids(k, "id wrap");
      check($sformatf("k%0d wrapped gen frame_id", k), {56'd0, fid[2*k]}, 64'd0);
      check($sformatf("k%0d scoreboard empty", k),
            64'(q0.size() + q1.size() + q2.size() + q3.size()), 64'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
